// File: rtl/fifo_traffic_driver.sv
// Stimulus engine for the FIFO write/read side: fill, drain, LFSR-random and
// flag-ignoring stress traffic with a sequential data pattern, plus response counters.
module fifo_traffic_driver #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_OPS    = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic                  i_full,
  input  logic                  i_empty,
  input  logic                  i_write_ack,
  input  logic                  i_overflow,
  input  logic                  i_underflow,
  output logic [DATA_WIDTH-1:0] o_data_in,
  output logic                  o_write_enable,
  output logic                  o_read_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_wr_cnt,
  output logic [15:0]           o_rd_cnt,
  output logic [15:0]           o_ack_cnt,
  output logic [15:0]           o_ovf_cnt,
  output logic [15:0]           o_udf_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {
    ModeFill   = 2'b00,
    ModeDrain  = 2'b01,
    ModeRandom = 2'b10,
    ModeStress = 2'b11
  } mode_e;

  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] LastOp  = 16'(NUM_OPS - 1);

  state_e                r_state;
  mode_e                 r_mode;
  logic [15:0]           r_lfsr;
  logic [15:0]           r_op_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_wr_cnt;
  logic [15:0]           r_rd_cnt;
  logic [15:0]           r_ack_cnt;
  logic [15:0]           r_ovf_cnt;
  logic [15:0]           r_udf_cnt;
  logic                  r_post;

  logic        w_run;
  logic        w_we;
  logic        w_re;
  logic        w_last;
  logic        w_op_step;
  logic        w_lfsr_adv;
  logic        w_lfsr_fb;
  logic [15:0] w_lfsr_next;
  logic        w_resp_win;

  assign w_run       = (r_state == StRun);
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_next = {r_lfsr[14:0], w_lfsr_fb};
  // Responses trail strobes by a cycle, so keep counting through DONE and one IDLE cycle.
  assign w_resp_win  = w_run || (r_state == StDone) || r_post;

  always_comb begin
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_last     = 1'b0;
    w_op_step  = 1'b0;
    w_lfsr_adv = 1'b0;
    if (w_run && !i_rst) begin
      unique case (r_mode)
        ModeFill: begin
          w_we      = !i_full;
          w_op_step = !i_full;
          w_last    = i_full || (r_op_cnt == LastOp);
        end
        ModeDrain: begin
          w_re      = !i_empty;
          w_op_step = !i_empty;
          w_last    = i_empty || (r_op_cnt == LastOp);
        end
        ModeRandom: begin
          w_we       = r_lfsr[0] & !i_full;
          w_re       = r_lfsr[1] & !i_empty;
          w_op_step  = 1'b1;
          w_lfsr_adv = 1'b1;
          w_last     = (r_op_cnt == LastOp);
        end
        ModeStress: begin
          w_we       = r_lfsr[0];
          w_re       = r_lfsr[1];
          w_op_step  = 1'b1;
          w_lfsr_adv = 1'b1;
          w_last     = (r_op_cnt == LastOp);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_mode    <= ModeFill;
      r_lfsr    <= SeedEff;
      r_op_cnt  <= '0;
      r_data    <= '0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_ack_cnt <= '0;
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
      r_post    <= 1'b0;
    end else begin
      r_post <= 1'b0;
      if (w_resp_win) begin
        r_ack_cnt <= r_ack_cnt + 16'(i_write_ack);
        r_ovf_cnt <= r_ovf_cnt + 16'(i_overflow);
        r_udf_cnt <= r_udf_cnt + 16'(i_underflow);
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state   <= StRun;
            r_mode    <= mode_e'(i_mode);
            r_lfsr    <= SeedEff;
            r_op_cnt  <= '0;
            r_data    <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_ack_cnt <= '0;
            r_ovf_cnt <= '0;
            r_udf_cnt <= '0;
          end
        end
        StRun: begin
          if (w_we) begin
            r_data   <= r_data + DATA_WIDTH'(1);
            r_wr_cnt <= r_wr_cnt + 16'd1;
          end
          if (w_re) begin
            r_rd_cnt <= r_rd_cnt + 16'd1;
          end
          if (w_op_step) begin
            r_op_cnt <= r_op_cnt + 16'd1;
          end
          if (w_lfsr_adv) begin
            r_lfsr <= w_lfsr_next;
          end
          if (w_last) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_post  <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_data_in      = r_data;
  assign o_write_enable = w_we;
  assign o_read_enable  = w_re;
  assign o_busy         = (r_state != StIdle);
  assign o_done         = (r_state == StDone);
  assign o_wr_cnt       = r_wr_cnt;
  assign o_rd_cnt       = r_rd_cnt;
  assign o_ack_cnt      = r_ack_cnt;
  assign o_ovf_cnt      = r_ovf_cnt;
  assign o_udf_cnt      = r_udf_cnt;

endmodule

// File: tb/tb_fifo_traffic_driver.sv
// Directed bench: two drivers (NUM_OPS 256 and 4), each attached to its own depth-8 FIFO model.
module tb_fifo_traffic_driver;

  localparam int Depth = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, st, full, empty, ack, ovf, udf, we, re, busy, done;
  logic [1:0]  md [2];
  logic [15:0] din [2], wrc [2], rdc [2], ackc [2], ovfc [2], udfc [2];

  int total = 0;
  int bad   = 0;

  fifo_traffic_driver #(.DATA_WIDTH(16), .NUM_OPS(256), .LFSR_SEED(16'hACE1)) u_dut_a (
    .i_clk(clk), .i_rst(rst[0]), .i_start(st[0]), .i_mode(md[0]),
    .i_full(full[0]), .i_empty(empty[0]), .i_write_ack(ack[0]), .i_overflow(ovf[0]),
    .i_underflow(udf[0]), .o_data_in(din[0]), .o_write_enable(we[0]), .o_read_enable(re[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_wr_cnt(wrc[0]), .o_rd_cnt(rdc[0]),
    .o_ack_cnt(ackc[0]), .o_ovf_cnt(ovfc[0]), .o_udf_cnt(udfc[0])
  );

  fifo_traffic_driver #(.DATA_WIDTH(16), .NUM_OPS(4), .LFSR_SEED(16'hACE1)) u_dut_b (
    .i_clk(clk), .i_rst(rst[1]), .i_start(st[1]), .i_mode(md[1]),
    .i_full(full[1]), .i_empty(empty[1]), .i_write_ack(ack[1]), .i_overflow(ovf[1]),
    .i_underflow(udf[1]), .o_data_in(din[1]), .o_write_enable(we[1]), .o_read_enable(re[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_wr_cnt(wrc[1]), .o_rd_cnt(rdc[1]),
    .o_ack_cnt(ackc[1]), .o_ovf_cnt(ovfc[1]), .o_udf_cnt(udfc[1])
  );

  // FIFO models: a write while full is rejected even if a read happens in the same cycle.
  logic [15:0] mem [2][Depth];
  int          cnt [2];
  int          wp  [2];
  int          rp  [2];

  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]  = (cnt[i] == Depth);
      empty[i] = (cnt[i] == 0);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        cnt[i] <= 0;
        wp[i]  <= 0;
        rp[i]  <= 0;
        ack[i] <= 1'b0;
        ovf[i] <= 1'b0;
        udf[i] <= 1'b0;
      end else begin
        ack[i] <= we[i] && !full[i];
        ovf[i] <= we[i] && full[i];
        udf[i] <= re[i] && empty[i];
        if (we[i] && !full[i]) begin
          mem[i][wp[i]] <= din[i];
          wp[i]         <= (wp[i] + 1) % Depth;
        end
        if (re[i] && !empty[i]) rp[i] <= (rp[i] + 1) % Depth;
        cnt[i] <= cnt[i] + ((we[i] && !full[i]) ? 1 : 0) - ((re[i] && !empty[i]) ? 1 : 0);
      end
    end
  end

  int         n_we, n_re, n_we_full, n_re_empty, n_done, n_busy, n_data_err, n_rd_err, n_full;
  logic [4:0] first_we, first_re;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a run on driver i, observe every busy cycle, then wait out the trailing response cycle.
  // A second start with mode DRAIN is pulsed at busy cycle 'poke' (negative: never).
  task automatic run(input int i, input logic [1:0] m, input int poke);
    int          n;
    int          rd_exp;
    logic [15:0] wexp;
    n_we = 0; n_re = 0; n_we_full = 0; n_re_empty = 0; n_done = 0; n_busy = 0;
    n_data_err = 0; n_rd_err = 0; n_full = 0; first_we = '0; first_re = '0;
    rd_exp = 0;
    wexp   = 16'd0;
    @(posedge clk); #1;
    st[i] = 1'b1;
    md[i] = m;
    @(posedge clk); #1;
    st[i] = 1'b0;
    n = 0;
    while (busy[i] === 1'b1 && n < 2000) begin
      st[i] = (n == poke);
      if (n == poke) md[i] = 2'b01;
      n_busy++;
      if (we[i]) begin
        if (din[i] !== wexp) n_data_err++;
        wexp++;
        n_we++;
        if (full[i]) n_we_full++;
      end
      if (re[i]) begin
        n_re++;
        if (empty[i]) n_re_empty++;
        else if (m == 2'b01) begin
          if (mem[i][rp[i]] !== 16'(rd_exp)) n_rd_err++;
          rd_exp++;
        end
      end
      if (full[i]) n_full++;
      if (n < 5) begin
        first_we[n[2:0]] = we[i];
        first_re[n[2:0]] = re[i];
      end
      if (done[i]) n_done++;
      @(posedge clk); #1;
      n++;
    end
    st[i] = 1'b0;
    chk("run_in_budget", 32'(n < 2000), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 2'b11;
    st    = 2'b00;
    md[0] = 2'b00;
    md[1] = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_a", 32'(we[0]), 32'd0);
    chk("rst_re_a", 32'(re[0]), 32'd0);
    chk("rst_busy_a", 32'(busy[0]), 32'd0);
    chk("rst_done_a", 32'(done[0]), 32'd0);
    chk("rst_din_a", 32'(din[0]), 32'd0);
    chk("rst_wrc_a", 32'(wrc[0]), 32'd0);
    chk("rst_ackc_b", 32'(ackc[1]), 32'd0);
    rst = 2'b00;

    // Fill empty depth-8 FIFO: 8 writes, one full cycle, then DONE.
    run(0, 2'b00, -1);
    chk("fill_wrc", 32'(wrc[0]), 32'd8);
    chk("fill_ackc", 32'(ackc[0]), 32'd8);
    chk("fill_ovfc", 32'(ovfc[0]), 32'd0);
    chk("fill_nwe", 32'(n_we), 32'd8);
    chk("fill_data", 32'(n_data_err), 32'd0);
    chk("fill_done", 32'(n_done), 32'd1);
    chk("fill_busy", 32'(n_busy), 32'd10);
    chk("fill_full", 32'(full[0]), 32'd1);

    // Drain it back: data leaves as 0..7.
    run(0, 2'b01, -1);
    chk("drain_rdc", 32'(rdc[0]), 32'd8);
    chk("drain_udfc", 32'(udfc[0]), 32'd0);
    chk("drain_wrc", 32'(wrc[0]), 32'd0);
    chk("drain_order", 32'(n_rd_err), 32'd0);
    chk("drain_nre", 32'(n_re), 32'd8);
    chk("drain_done", 32'(n_done), 32'd1);
    chk("drain_busy", 32'(n_busy), 32'd10);
    chk("drain_empty", 32'(empty[1'b0]), 32'd1);

    // NUM_OPS=4 stops by count before the FIFO fills.
    run(1, 2'b00, -1);
    chk("small_wrc", 32'(wrc[1]), 32'd4);
    chk("small_ackc", 32'(ackc[1]), 32'd4);
    chk("small_ovfc", 32'(ovfc[1]), 32'd0);
    chk("small_full_seen", 32'(n_full), 32'd0);
    chk("small_busy", 32'(n_busy), 32'd5);
    chk("small_data", 32'(n_data_err), 32'd0);
    chk("small_fifo_cnt", 32'(cnt[1]), 32'd4);

    // Refill, then stress the full FIFO.
    run(0, 2'b00, -1);
    chk("refill_full", 32'(full[0]), 32'd1);
    run(0, 2'b11, -1);
    chk("stress_first_we", 32'(first_we), 32'b01111);
    chk("stress_first_re", 32'(first_re), 32'b11110);
    chk("stress_wrc", 32'(wrc[0]), 32'(n_we));
    chk("stress_rdc", 32'(rdc[0]), 32'(n_re));
    chk("stress_ovfc", 32'(ovfc[0]), 32'(n_we_full));
    chk("stress_udfc", 32'(udfc[0]), 32'(n_re_empty));
    chk("stress_ack_sum", 32'(ackc[0]) + 32'(ovfc[0]), 32'(wrc[0]));
    chk("stress_ovf_seen", 32'(n_we_full != 0), 32'd1);
    chk("stress_data", 32'(n_data_err), 32'd0);
    chk("stress_busy", 32'(n_busy), 32'd257);

    // Random traffic is flag-gated: no overflow or underflow.
    run(0, 2'b10, -1);
    chk("rand_ovfc", 32'(ovfc[0]), 32'd0);
    chk("rand_udfc", 32'(udfc[0]), 32'd0);
    chk("rand_ack", 32'(ackc[0]), 32'(wrc[0]));
    chk("rand_wrc", 32'(wrc[0]), 32'(n_we));
    chk("rand_rdc", 32'(rdc[0]), 32'(n_re));
    chk("rand_nwe", 32'(n_we != 0), 32'd1);
    chk("rand_busy", 32'(n_busy), 32'd257);

    // Reset in the middle of a fill after 3 writes.
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    st[1]  = 1'b1;
    md[1]  = 2'b00;
    @(posedge clk); #1;
    st[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_wrc", 32'(wrc[1]), 32'd3);
    chk("midrst_we_before", 32'(we[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    chk("midrst_we_gate", 32'(we[1]), 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("midrst_busy", 32'(busy[1]), 32'd0);
    chk("midrst_din", 32'(din[1]), 32'd0);
    n_done = 0;
    repeat (5) begin
      if (done[1]) n_done++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);

    // Start pulsed while busy must not restart or change mode.
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    run(0, 2'b00, 3);
    chk("busy_start_wrc", 32'(wrc[0]), 32'd8);
    chk("busy_start_rdc", 32'(rdc[0]), 32'd0);
    chk("busy_start_ackc", 32'(ackc[0]), 32'd8);
    chk("busy_start_done", 32'(n_done), 32'd1);
    chk("busy_start_busy", 32'(n_busy), 32'd10);
    chk("busy_start_data", 32'(n_data_err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_hold_wrc", 32'(wrc[0]), 32'd8);
    chk("idle_hold_busy", 32'(busy[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
